fft256_seq_ctrl: RTL and testbench
==================================

// Module: fft256_seq_ctrl
// PURPOSE
//  Sequencer for the memory-based 256-point radix-2 FFT core. It runs four phases:
//  - LOAD: collects 256 input samples and writes each one to its bit-reversed address.
//  - CALC: issues 8 stages x 128 butterflies, one per cycle, with A/B and twiddle addresses.
//  - DRAIN: waits for the butterfly pipeline write-back between stages.
//  - UNLOAD: reads results out in natural order with valid_out/sop_out framing.
//  Datapath (sample RAM, twiddle ROM, butterfly) lives outside; this block owns only sequencing.
// PARAMETERS
//  N        256  FFT points; fixed at 256, and LOGN = 8 is derived from it
//  BFLY_LAT 3    cycles from butterfly issue to write-back enable (>=1)
//  RD_LAT   1    sample-RAM read latency, in cycles, during UNLOAD
// PORTS
//  clk        in  1  clock
//  rst_n      in  1  asynchronous active-low reset
//  inv        in  1  inverse-FFT request; sampled on the accepted sop_in beat
//  valid_in   in  1  input sample valid
//  sop_in     in  1  first sample of frame; qualified by valid_in
//  in_ready   out 1  high in IDLE and LOAD; inputs are ignored when low
//  ld_we      out 1  sample-RAM load write enable (= valid_in & in_ready & frame active)
//  ld_addr    out 8  bit-reversed load address
//  bf_issue   out 1  butterfly operands valid this cycle
//  bf_a_addr  out 8  butterfly top address
//  bf_b_addr  out 8  butterfly bottom address (bf_a_addr + 2^stage)
//  tw_addr    out 7  twiddle ROM index
//  tw_conj    out 1  conjugate twiddle (latched inv)
//  wb_we      out 1  write-back enable (bf_issue delayed by BFLY_LAT)
//  wb_a_addr  out 8  bf_a_addr delayed by BFLY_LAT
//  wb_b_addr  out 8  bf_b_addr delayed by BFLY_LAT
//  stage      out 3  current stage, 0..7
//  rd_addr    out 8  result read address during UNLOAD
//  valid_out  out 1  result valid (rd strobe delayed by RD_LAT)
//  sop_out    out 1  high with the first valid_out of a frame
// BEHAVIOUR
//  Reset: state = IDLE, all counters 0, all outputs 0 except in_ready = 1.
//  IDLE -> LOAD on valid_in & sop_in. That beat is sample 0 and ld_we asserts on it.
//  LOAD:
//  - Count cnt (8b) advances on each valid_in; gaps hold cnt.
//  - ld_addr = bitrev8(cnt), combinational from cnt and the current beat.
//  - valid_in & sop_in while in LOAD restarts the frame: cnt = 0, that beat is sample 0, inv re-latched.
//  - On the accepted beat with cnt == 255 -> CALC; in_ready drops the next cycle.
//  - valid_in without sop_in while IDLE is dropped.
//  CALC, butterfly counter j (7b), stage s, one issue per cycle:
//  - pos = j & (2^s - 1); grp = j >> s.
//  - a = (grp << (s+1)) | pos; b = a + 2^s; tw = pos << (7 - s).
//  - After j == 127 -> DRAIN, unless s == 7 -> DRAIN_LAST.
//  DRAIN: holds BFLY_LAT cycles with bf_issue = 0, then s++, j = 0, back to CALC. This prevents stage RAW hazards.
//  DRAIN_LAST: holds BFLY_LAT cycles, then -> UNLOAD with rd counter = 0.
//  wb_* is a BFLY_LAT-deep shift of the issue signals and runs independently of state.
//  UNLOAD:
//  - rd_addr = 0..255, one per cycle, with no backpressure.
//  - valid_out/sop_out are the rd strobe and rd == 0 delayed RD_LAT cycles.
//  - After rd == 255 -> IDLE; the RD_LAT tail still emits.
//  Latency: last input beat -> first valid_out = 1 + 8*(128 + BFLY_LAT) + RD_LAT cycles.
//  Frame period is >= that latency + 256; a new frame is accepted only once in IDLE.
//  tw_conj = inv latched at sop; it is constant for the whole frame.
//  Async reset mid-frame aborts immediately. Pending wb/valid pipeline contents are cleared.
// CONFIGURATION
//  FFT_CTRL_STAGE_SCALE_EN:
//  - Defined: adds output bf_scale (1b), the per-stage divide-by-2 flag, valid with bf_issue and delayed with wb_we.
//  - bf_scale = 1 in every stage when tw_conj = 0 (forward), giving 1/N overall.
//  - bf_scale = 0 for the inverse.
//  - Undefined: the port is absent; the datapath never scales.
// STRUCTURE
//  Shared package fft256_pkg:
//  - localparams FFT_N = 256, FFT_LOGN = 8.
//  - state enum {IDLE, LOAD, CALC, DRAIN, DRAIN_LAST, UNLOAD}.
//  - function bitrev8.
//  - function bfly_addr(s, j) returning {a, b, tw}.
//  Sub-module fft256_dly_line (WIDTH, DEPTH): reset-clearable shift register, used for the wb_* and valid_out/sop_out delays.
// TESTING
//  1 Reset then 256 beats x = k, sop on k = 0:
//    - ld_addr sequence is 0,128,64,192,...
//    - in_ready drops the cycle after beat 255.
//  2 CALC trace with BFLY_LAT = 3:
//    - s = 0, j = 5 -> a = 10, b = 11, tw = 0.
//    - s = 3, j = 13 -> a = 21, b = 29, tw = 80.
//    - s = 7, j = 127 -> a = 127, b = 255, tw = 127.
//    - Exactly 3 idle cycles between stages.
//  3 Full frame:
//    - valid_out rises 1 + 8*131 + 1 = 1050 cycles after the last input beat, with sop_out on rd = 0.
//    - 256 contiguous valid_out, then IDLE.
//  4 sop_in re-asserted at sample 100 of a LOAD: cnt restarts, ld_addr = 0 on that beat, inv re-latched (inv = 1 -> tw_conj = 1).
//  5 valid_in gaps every other cycle in LOAD: cnt advances only on valid beats; inputs during CALC/UNLOAD are ignored (no ld_we).
//  6 rst_n pulsed mid-CALC: all outputs are at reset values asynchronously, and no wb_we appears after release.

Source files
------------

// File: rtl/fft256_seq_ctrl_pkg.sv
// fft256_pkg: shared types and helpers for the 256-point FFT sequencer.
//   FFT_N / FFT_LOGN : transform size and stage count
//   state_t          : sequencer phases
//   bfly_t           : butterfly A/B sample addresses plus twiddle index
//   bitrev8()        : 8-bit bit reversal used for the load order
//   bfly_addr(s, j)  : butterfly j of stage s -> {a, b, tw}
package fft256_pkg;

   localparam int FFT_N    = 256;
   localparam int FFT_LOGN = 8;

   typedef enum logic [2:0] {
      IDLE, LOAD, CALC, DRAIN, DRAIN_LAST, UNLOAD
   } state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [6:0] tw;
   } bfly_t;

   function automatic logic [7:0] bitrev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // pos selects the element inside a group of 2^s pairs, grp selects the
   // group; each group spans 2^(s+1) samples. The twiddle step halves with
   // every stage, so pos is scaled up to the 128-entry ROM.
   function automatic bfly_t bfly_addr(input logic [2:0] s, input logic [6:0] j);
      bfly_t      r;
      logic [7:0] half;
      logic [7:0] pos;
      logic [7:0] grp;
      half = 8'd1 << s;
      pos  = {1'b0, j} & (half - 8'd1);
      grp  = {1'b0, j} >> s;
      r.a  = (grp << ({1'b0, s} + 4'd1)) | pos;
      r.b  = r.a + half;
      r.tw = 7'(pos << (3'd7 - s));
      return r;
   endfunction

endpackage

// File: rtl/fft256_seq_ctrl_if.sv
// fft256_seq_ctrl_if: all sequencer-facing signals of the FFT core.
//   inputs : inv, valid_in, sop_in
//   load   : in_ready, ld_we, ld_addr
//   calc   : bf_issue, bf_a_addr, bf_b_addr, tw_addr, tw_conj, stage
//   wback  : wb_we, wb_a_addr, wb_b_addr
//   unload : rd_addr, valid_out, sop_out
// Macro FFT_CTRL_STAGE_SCALE_EN adds bf_scale (per-stage divide-by-2).
// Handshake: a sample is taken on any cycle with valid_in & in_ready; there
// is no backpressure on the output side, valid_out is a pure strobe.
interface fft256_seq_ctrl_if;
   logic       inv;
   logic       valid_in;
   logic       sop_in;
   logic       in_ready;
   logic       ld_we;
   logic [7:0] ld_addr;
   logic       bf_issue;
   logic [7:0] bf_a_addr;
   logic [7:0] bf_b_addr;
   logic [6:0] tw_addr;
   logic       tw_conj;
   logic       wb_we;
   logic [7:0] wb_a_addr;
   logic [7:0] wb_b_addr;
   logic [2:0] stage;
   logic [7:0] rd_addr;
   logic       valid_out;
   logic       sop_out;
`ifdef FFT_CTRL_STAGE_SCALE_EN
   logic       bf_scale;
`endif

   modport slave (
      input  inv, valid_in, sop_in,
`ifdef FFT_CTRL_STAGE_SCALE_EN
      output bf_scale,
`endif
      output in_ready, ld_we, ld_addr, bf_issue, bf_a_addr, bf_b_addr,
             tw_addr, tw_conj, wb_we, wb_a_addr, wb_b_addr, stage,
             rd_addr, valid_out, sop_out
   );

   modport master (
      output inv, valid_in, sop_in,
`ifdef FFT_CTRL_STAGE_SCALE_EN
      input  bf_scale,
`endif
      input  in_ready, ld_we, ld_addr, bf_issue, bf_a_addr, bf_b_addr,
             tw_addr, tw_conj, wb_we, wb_a_addr, wb_b_addr, stage,
             rd_addr, valid_out, sop_out
   );
endinterface

// File: rtl/fft256_dly_line.sv
// fft256_dly_line: DEPTH-stage shift register, cleared by async reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : WIDTH-bit input
//   q_o        : d_i delayed by DEPTH cycles (DEPTH >= 1)
module fft256_dly_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] sr_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft256_seq_ctrl.sv
// fft256_seq_ctrl: LOAD / CALC / DRAIN / UNLOAD sequencer of the
// memory-based 256-point radix-2 FFT. Owns only addresses and strobes.
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : fft256_seq_ctrl_if.slave (sample input, RAM/ROM addresses,
//                write-back, result framing)
//   state_o    : current sequencer state, for debug/observation
// Parameters: BFLY_LAT (issue -> write-back, >=1), RD_LAT (RAM read, >=1).
// Macro FFT_CTRL_STAGE_SCALE_EN adds io.bf_scale.
module fft256_seq_ctrl
   import fft256_pkg::*;
#(
   parameter int BFLY_LAT = 3,
   parameter int RD_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   fft256_seq_ctrl_if.slave io,
   output state_t           state_o
);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [6:0] j_q, j_d;
   logic [2:0] s_q, s_d;
   logic [7:0] dcnt_q, dcnt_d;
   logic [7:0] rd_q, rd_d;
   logic       inv_q, inv_d;

   logic       in_ready_c, ld_we_c, issue_c, rd_stb_c;
   logic [7:0] ld_addr_c;
   logic       drain_done;
   bfly_t      bf;
   logic [16:0] wb_vec;
   logic [1:0]  vo_vec;

   assign bf         = bfly_addr(s_q, j_q);
   assign drain_done = (dcnt_q == 8'(BFLY_LAT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         j_q     <= '0;
         s_q     <= '0;
         dcnt_q  <= '0;
         rd_q    <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         s_q     <= s_d;
         dcnt_q  <= dcnt_d;
         rd_q    <= rd_d;
         inv_q   <= inv_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      j_d        = j_q;
      s_d        = s_q;
      dcnt_d     = dcnt_q;
      rd_d       = rd_q;
      inv_d      = inv_q;
      in_ready_c = 1'b0;
      ld_we_c    = 1'b0;
      ld_addr_c  = '0;
      issue_c    = 1'b0;
      rd_stb_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (io.valid_in && io.sop_in) begin
               ld_we_c = 1'b1;
               cnt_d   = 8'd1;
               inv_d   = io.inv;
               j_d     = '0;
               s_d     = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            in_ready_c = 1'b1;
            ld_addr_c  = bitrev8(cnt_q);
            if (io.valid_in) begin
               ld_we_c = 1'b1;
               // A new sop restarts the frame and takes this beat as sample 0.
               if (io.sop_in) begin
                  ld_addr_c = '0;
                  cnt_d     = 8'd1;
                  inv_d     = io.inv;
               end else if (cnt_q == 8'(FFT_N - 1)) begin
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         CALC: begin
            issue_c = 1'b1;
            if (j_q == 7'd127) begin
               j_d     = '0;
               dcnt_d  = '0;
               state_d = (s_q == 3'(FFT_LOGN - 1)) ? DRAIN_LAST : DRAIN;
            end else begin
               j_d = j_q + 7'd1;
            end
         end
         // Stall until the last write-back of this stage has landed so the
         // next stage never reads a stale sample.
         DRAIN: begin
            if (drain_done) begin
               dcnt_d  = '0;
               s_d     = s_q + 3'd1;
               state_d = CALC;
            end else begin
               dcnt_d = dcnt_q + 8'd1;
            end
         end
         DRAIN_LAST: begin
            if (drain_done) begin
               dcnt_d  = '0;
               s_d     = '0;
               rd_d    = '0;
               state_d = UNLOAD;
            end else begin
               dcnt_d = dcnt_q + 8'd1;
            end
         end
         UNLOAD: begin
            rd_stb_c = 1'b1;
            if (rd_q == 8'd255) begin
               rd_d    = '0;
               state_d = IDLE;
            end else begin
               rd_d = rd_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign io.in_ready  = in_ready_c;
   assign io.ld_we     = ld_we_c;
   assign io.ld_addr   = ld_addr_c;
   assign io.bf_issue  = issue_c;
   assign io.bf_a_addr = issue_c ? bf.a  : '0;
   assign io.bf_b_addr = issue_c ? bf.b  : '0;
   assign io.tw_addr   = issue_c ? bf.tw : '0;
   assign io.tw_conj   = inv_q;
   assign io.stage     = s_q;
   assign io.rd_addr   = rd_stb_c ? rd_q : '0;
   assign state_o      = state_q;

   fft256_dly_line #(.WIDTH(17), .DEPTH(BFLY_LAT)) u_wb_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({issue_c, io.bf_a_addr, io.bf_b_addr}),
      .q_o   (wb_vec)
   );
   assign io.wb_we     = wb_vec[16];
   assign io.wb_a_addr = wb_vec[15:8];
   assign io.wb_b_addr = wb_vec[7:0];

   fft256_dly_line #(.WIDTH(2), .DEPTH(RD_LAT)) u_vo_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({rd_stb_c, rd_stb_c & (rd_q == 8'd0)}),
      .q_o   (vo_vec)
   );
   assign io.valid_out = vo_vec[1];
   assign io.sop_out   = vo_vec[0];

`ifdef FFT_CTRL_STAGE_SCALE_EN
   // Forward transforms halve every stage (1/N overall); inverse never scales.
   // The flag is frame-constant, so it is valid both at issue and write-back.
   assign io.bf_scale = ~inv_q & (issue_c | wb_vec[16]);
`endif
endmodule

// File: tb/tb_fft256_seq_ctrl.sv
// tb_fft256_seq_ctrl: self-checking bench for fft256_seq_ctrl.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_fft256_seq_ctrl;
   import fft256_pkg::*;

   localparam int BFLY_LAT = 3;
   localparam int RD_LAT   = 1;
   localparam int STG_CYC  = 128 + BFLY_LAT;
   // Cycle numbers counted from the last accepted input beat (= cycle 0).
   localparam int T_UNLOAD = 1 + 8 * STG_CYC;
   localparam int T_VALID  = T_UNLOAD + RD_LAT;
   localparam int T_END    = T_UNLOAD + 256 + RD_LAT + 5;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;
   int     n_tests = 0;
   int     n_fail  = 0;

   fft256_seq_ctrl_if io ();

   fft256_seq_ctrl #(.BFLY_LAT(BFLY_LAT), .RD_LAT(RD_LAT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io      (io),
      .state_o (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] outs_vec();
      return {io.ld_we, io.ld_addr, io.bf_issue, io.bf_a_addr, io.bf_b_addr,
              io.tw_addr, io.tw_conj, io.wb_we, io.wb_a_addr, io.wb_b_addr,
              io.stage, io.rd_addr, io.valid_out, io.sop_out};
   endfunction

   function automatic int ref_bitrev(input int k);
      int r = 0;
      int x = k;
      for (int i = 0; i < 8; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   task automatic test_reset();
      io.inv = 1'b0; io.valid_in = 1'b0; io.sop_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (outs_vec() !== 64'd0) begin
         n_fail++; $display("FAIL reset_outs: got %h expected 0", outs_vec());
      end
      n_tests++;
      if (io.in_ready !== 1'b1 || dbg_state !== IDLE) begin
         n_fail++; $display("FAIL reset_ready: in_ready=%b state=%0d expected 1/IDLE", io.in_ready, dbg_state);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (outs_vec() !== 64'd0 || io.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_idle: outs=%h in_ready=%b", outs_vec(), io.in_ready);
      end
   endtask

   // mode 0: no gaps, 1: valid every other cycle, 2: random gaps.
   task automatic run_load(input int mode, input int restart_at, input logic first_inv,
                           input logic restart_inv, output logic exp_conj);
      int   k = 0;
      int   it = 0;
      bit   started = 0;
      bit   restarted = 0;
      logic v, sp, iv;
      exp_conj = first_inv;
      // Non-sop beats in IDLE are dropped.
      for (int i = 0; i < 3; i++) begin
         io.valid_in = 1'b1; io.sop_in = 1'b0; io.inv = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_tests++;
         if (io.ld_we !== 1'b0 || io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_drop: ld_we=%b in_ready=%b expected 0/1", io.ld_we, io.in_ready);
         end
         @(posedge clk); #1;
      end
      while (k < 256 && it < 3000) begin
         if (!started) v = 1'b1;
         else if (mode == 0) v = 1'b1;
         else if (mode == 1) v = (it % 2 == 0);
         else v = 1'($urandom_range(0, 1));
         sp = 1'b0;
         iv = 1'($urandom_range(0, 1));
         if (!started) begin
            sp = 1'b1; iv = first_inv;
         end else if (v && !restarted && k == restart_at) begin
            sp = 1'b1; iv = restart_inv; restarted = 1;
         end else if (!v) begin
            sp = 1'($urandom_range(0, 1));
         end
         io.valid_in = v; io.sop_in = sp; io.inv = iv;
         @(negedge clk);
         n_tests++;
         if (io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_ready: beat %0d got %b expected 1", k, io.in_ready);
         end
         n_tests++;
         if (io.ld_we !== v) begin
            n_fail++; $display("FAIL load_we: beat %0d got %b expected %b", k, io.ld_we, v);
         end
         if (v) begin
            n_tests++;
            if (io.ld_addr !== 8'(ref_bitrev(sp ? 0 : k))) begin
               n_fail++; $display("FAIL load_addr: sample %0d got %0d expected %0d", sp ? 0 : k, io.ld_addr, ref_bitrev(sp ? 0 : k));
            end
            if (sp) begin
               k = 1; exp_conj = iv; started = 1;
            end else begin
               k++;
            end
         end
         it++;
         @(posedge clk); #1;
      end
      io.valid_in = 1'b0; io.sop_in = 1'b0;
      n_tests++;
      if (k != 256) begin
         n_fail++; $display("FAIL load_timeout: accepted %0d expected 256", k);
      end
   endtask

   task automatic run_calc_unload(input logic exp_conj, input bit junk);
      logic [25:0] exp_q[$];
      logic [15:0] wb_q[$];
      logic [25:0] e;
      logic [15:0] w;
      int          sm, off, tw3, idx;
      bit          iss_m, wb_m, vo_m;
      // Reference order: stage, then group, then position inside the group.
      for (int s = 0; s < 8; s++) begin
         int half = 1 << s;
         for (int g = 0; g < 128 / half; g++) begin
            for (int p = 0; p < half; p++) begin
               int a = g * 2 * half + p;
               exp_q.push_back({3'(s), 8'(a), 8'(a + half), 7'(p * (128 / half))});
               wb_q.push_back({8'(a), 8'(a + half)});
            end
         end
      end
      for (int t = 1; t <= T_END; t++) begin
         if (junk && t <= T_UNLOAD + 250) begin
            io.valid_in = 1'($urandom_range(0, 1));
            io.sop_in   = 1'($urandom_range(0, 1));
            io.inv      = 1'($urandom_range(0, 1));
         end else begin
            io.valid_in = 1'b0; io.sop_in = 1'b0;
         end
         @(negedge clk);
         sm    = (t - 1) / STG_CYC;
         off   = (t - 1) % STG_CYC;
         iss_m = (t < T_UNLOAD) && (off < 128);
         tw3   = t - BFLY_LAT;
         wb_m  = (tw3 >= 1) && (tw3 < T_UNLOAD) && (((tw3 - 1) % STG_CYC) < 128);
         vo_m  = (t >= T_VALID) && (t < T_VALID + 256);
         n_tests++;
         if (io.bf_issue !== iss_m) begin
            n_fail++; $display("FAIL bf_issue: cycle %0d got %b expected %b", t, io.bf_issue, iss_m);
         end
         if (iss_m && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            idx = sm * 128 + off;
            n_tests++;
            if ({io.stage, io.bf_a_addr, io.bf_b_addr, io.tw_addr} !== e) begin
               n_fail++; $display("FAIL bfly %0d: got s=%0d a=%0d b=%0d tw=%0d expected s=%0d a=%0d b=%0d tw=%0d", idx,
                  io.stage, io.bf_a_addr, io.bf_b_addr, io.tw_addr, e[25:23], e[22:15], e[14:7], e[6:0]);
            end
            if (idx == 5 || idx == 3 * 128 + 13 || idx == 1023) begin
               n_tests++;
               if ((idx == 5 && {io.bf_a_addr, io.bf_b_addr, io.tw_addr} !== {8'd10, 8'd11, 7'd0}) ||
                   (idx == 397 && {io.bf_a_addr, io.bf_b_addr, io.tw_addr} !== {8'd21, 8'd29, 7'd80}) ||
                   (idx == 1023 && {io.bf_a_addr, io.bf_b_addr, io.tw_addr} !== {8'd127, 8'd255, 7'd127})) begin
                  n_fail++; $display("FAIL bfly_spot %0d: got a=%0d b=%0d tw=%0d", idx, io.bf_a_addr, io.bf_b_addr, io.tw_addr);
               end
            end
`ifdef FFT_CTRL_STAGE_SCALE_EN
            n_tests++;
            if (io.bf_scale !== ~exp_conj) begin
               n_fail++; $display("FAIL bf_scale: got %b expected %b", io.bf_scale, ~exp_conj);
            end
`endif
         end
         if (t < T_UNLOAD) begin
            n_tests++;
            if (io.stage !== 3'(sm)) begin
               n_fail++; $display("FAIL stage: cycle %0d got %0d expected %0d", t, io.stage, sm);
            end
         end
         n_tests++;
         if (io.wb_we !== wb_m) begin
            n_fail++; $display("FAIL wb_we: cycle %0d got %b expected %b", t, io.wb_we, wb_m);
         end
         if (wb_m && wb_q.size() > 0) begin
            w = wb_q.pop_front();
            n_tests++;
            if ({io.wb_a_addr, io.wb_b_addr} !== w) begin
               n_fail++; $display("FAIL wb_addr: cycle %0d got a=%0d b=%0d expected a=%0d b=%0d", t, io.wb_a_addr, io.wb_b_addr, w[15:8], w[7:0]);
            end
         end
         n_tests++;
         if (io.ld_we !== 1'b0 || io.in_ready !== (t >= T_UNLOAD + 256)) begin
            n_fail++; $display("FAIL busy_inputs: cycle %0d ld_we=%b in_ready=%b", t, io.ld_we, io.in_ready);
         end
         n_tests++;
         if (io.tw_conj !== exp_conj) begin
            n_fail++; $display("FAIL tw_conj: cycle %0d got %b expected %b", t, io.tw_conj, exp_conj);
         end
         n_tests++;
         if (io.valid_out !== vo_m || io.sop_out !== (t == T_VALID)) begin
            n_fail++; $display("FAIL framing: cycle %0d valid_out=%b sop_out=%b expected %b/%b", t, io.valid_out, io.sop_out, vo_m, t == T_VALID);
         end
         if (t >= T_UNLOAD && t < T_UNLOAD + 256) begin
            n_tests++;
            if (io.rd_addr !== 8'(t - T_UNLOAD)) begin
               n_fail++; $display("FAIL rd_addr: cycle %0d got %0d expected %0d", t, io.rd_addr, t - T_UNLOAD);
            end
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (exp_q.size() != 0 || wb_q.size() != 0) begin
         n_fail++; $display("FAIL calc_count: %0d issues and %0d write-backs missing", exp_q.size(), wb_q.size());
      end
   endtask

   task automatic test_full_frame();
      logic c;
      run_load(0, -1, 1'($urandom_range(0, 1)), 1'b0, c);
      run_calc_unload(c, 0);
   endtask

   task automatic test_restart();
      logic c;
      run_load(0, 100, 1'b0, 1'b1, c);
      run_calc_unload(c, 0);
   endtask

   task automatic test_gaps_and_junk();
      logic c;
      run_load(1, -1, 1'($urandom_range(0, 1)), 1'b0, c);
      run_calc_unload(c, 1);
   endtask

   task automatic test_random_gaps();
      logic c;
      run_load(2, int'($urandom_range(1, 250)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
      run_calc_unload(c, 1);
   endtask

   task automatic test_reset_mid_calc();
      logic c;
      run_load(0, -1, 1'b1, 1'b0, c);
      repeat (200) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (outs_vec() !== 64'd0 || io.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL async_reset: outs=%h in_ready=%b expected 0/1", outs_vec(), io.in_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++;
         if (io.wb_we !== 1'b0 || io.bf_issue !== 1'b0 || io.valid_out !== 1'b0 || io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_reset: cycle %0d wb_we=%b bf_issue=%b valid_out=%b in_ready=%b", i,
               io.wb_we, io.bf_issue, io.valid_out, io.in_ready);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_restart();
      test_gaps_and_junk();
      test_random_gaps();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
